// File: rtl/pc_gen_pkg.sv
// Shared definitions for the next-PC generator and its branch target buffer.
// NPC op codes mirror the ctrl_encode_def.v encodings used by the decoder.
// Counter states and update kinds are typed so the BTB logic reads clearly.
package pc_gen_pkg;

    // NPC operation codes carried down the pipe with each instruction.
    localparam logic [4:0] NPC_PLUS4  = 5'b00000;
    localparam logic [4:0] NPC_BRANCH = 5'b00001;
    localparam logic [4:0] NPC_JUMP   = 5'b00010;
    localparam logic [4:0] NPC_JALR   = 5'b00100;

    // 2-bit saturating direction counter: bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,   // strongly not taken
        CTR_WNT = 2'd1,   // weakly not taken
        CTR_WT  = 2'd2,   // weakly taken
        CTR_ST  = 2'd3    // strongly taken
    } ctr_t;

    // Value after reset, on allocation by a taken branch, and on jumps.
    localparam ctr_t CTR_RESET = CTR_SNT;
    localparam ctr_t CTR_ALLOC = CTR_WT;
    localparam ctr_t CTR_JUMP  = CTR_ST;

    // What a resolved instruction does to its BTB slot.
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,  // leave the slot alone
        UPD_TRAIN = 2'd1,  // existing branch entry: move counter, maybe retarget
        UPD_ALLOC = 2'd2,  // (re)write valid, tag, target and counter
        UPD_INVAL = 2'd3   // non-control instruction aliased onto an entry
    } upd_kind_t;

    // Architectural taken outcome: jumps always, branches as resolved,
    // sequential and unknown ops never.
    function automatic logic op_taken(input logic [4:0] op, input logic br_taken);
        logic t;
        t = 1'b0;
        case (op)
            NPC_BRANCH:         t = br_taken;
            NPC_JUMP, NPC_JALR: t = 1'b1;
            default:            t = 1'b0;
        endcase
        return t;
    endfunction

    // Saturating step of the direction counter towards the observed outcome.
    function automatic ctr_t ctr_step(input ctr_t c, input logic up);
        ctr_t r;
        r = c;
        case (c)
            CTR_SNT: r = up ? CTR_WNT : CTR_SNT;
            CTR_WNT: r = up ? CTR_WT  : CTR_SNT;
            CTR_WT:  r = up ? CTR_ST  : CTR_WNT;
            CTR_ST:  r = up ? CTR_ST  : CTR_WT;
            default: r = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: valid/tag/target/counter per slot.
// Lookup is combinational from the registered table; updates land on the next edge.
// No backpressure: the owner gates wr_en (a stalled or invalid EX writes nothing).
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rstn,
    // read port: fetch-side lookup
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_target,
    // write port: EX-side resolve/update
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [4:0]      wr_op,
    input  logic            wr_taken,
    input  logic [XLEN-1:0] wr_target
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - 2 - IDX;

    logic              vld_q [ENTRIES];
    ctr_t              ctr_q [ENTRIES];
    logic [TAGW-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]   tgt_q [ENTRIES];

    logic [IDX-1:0]    rd_idx;
    logic [TAGW-1:0]   rd_tag;
    logic              rd_hit;
    logic [IDX-1:0]    wr_idx;
    logic [TAGW-1:0]   wr_tag;
    logic              wr_hit;
    upd_kind_t         upd_kind;
    ctr_t              nxt_ctr;

    // Instructions are word aligned, so the two LSBs never reach the table.
    logic              unused_lsb;
    assign unused_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_idx = rd_pc[2 +: IDX];
    assign rd_tag = rd_pc[XLEN-1 -: TAGW];
    assign wr_idx = wr_pc[2 +: IDX];
    assign wr_tag = wr_pc[XLEN-1 -: TAGW];

    // Lookup: a hit needs a valid slot with a matching tag; predict on counter MSB.
    always_comb begin
        rd_hit    = vld_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_taken  = rd_hit && ctr_q[rd_idx][1];
        rd_target = tgt_q[rd_idx];
    end

    // Classify the resolved instruction into an update kind and new counter value.
    always_comb begin
        upd_kind = UPD_NONE;
        nxt_ctr  = ctr_q[wr_idx];
        wr_hit   = vld_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        if (wr_en) begin
            case (wr_op)
                NPC_BRANCH: begin
                    if (wr_hit) begin
                        upd_kind = UPD_TRAIN;
                        nxt_ctr  = ctr_step(ctr_q[wr_idx], wr_taken);
                    end else if (wr_taken) begin
                        // Not-taken misses are not worth a slot: the default
                        // pc+4 prediction already covers them.
                        upd_kind = UPD_ALLOC;
                        nxt_ctr  = CTR_ALLOC;
                    end
                end
                NPC_JUMP, NPC_JALR: begin
                    upd_kind = UPD_ALLOC;
                    nxt_ctr  = CTR_JUMP;
                end
                NPC_PLUS4: begin
                    if (wr_hit) begin
                        upd_kind = UPD_INVAL;
                    end
                end
                default: upd_kind = UPD_NONE;
            endcase
        end
    end

    // Control state (valid + counter) is reset; a reset drops any pending update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                vld_q[i] <= 1'b0;
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            case (upd_kind)
                UPD_TRAIN: ctr_q[wr_idx] <= nxt_ctr;
                UPD_ALLOC: begin
                    vld_q[wr_idx] <= 1'b1;
                    ctr_q[wr_idx] <= nxt_ctr;
                end
                UPD_INVAL: vld_q[wr_idx] <= 1'b0;
                default: ;
            endcase
        end
    end

    // Tag/target payload needs no reset: it is only observed behind a valid bit,
    // and a write slipping in during reset lands in a slot that stays invalid.
    always_ff @(posedge clk) begin
        if (upd_kind == UPD_ALLOC) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= wr_target;
        end else if (upd_kind == UPD_TRAIN && wr_taken) begin
            tgt_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: fetch-PC register, BTB-based prediction, EX resolve and redirect.
// Redirect latency 1 cycle (mispredict in N gives pc=actual_next in N+1); flush is combinational.
// stall holds pc and blocks BTB training; a mispredict overrides stall for the pc only.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16   // power of two, >= 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [4:0]      ex_npc_op,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush,
    output logic [31:0]     mispred_cnt
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [XLEN-1:0] btb_target;
    logic            btb_taken;
    logic            ex_taken_act;
    logic [XLEN-1:0] actual_next;
    logic            mispredict;
    logic            btb_wr_en;
    logic [XLEN-1:0] pc_d;

    // The carried prediction is fully described by its target; the taken bit
    // travels for the benefit of other stages only.
    logic            unused_pred_taken;
    assign unused_pred_taken = ex_pred_taken;

    pc_gen_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rstn      (rstn),
        .rd_pc     (pc),
        .rd_taken  (btb_taken),
        .rd_target (btb_target),
        .wr_en     (btb_wr_en),
        .wr_pc     (ex_pc),
        .wr_op     (ex_npc_op),
        .wr_taken  (ex_taken_act),
        .wr_target (ex_target)
    );

    // Fetch-side prediction from the current pc.
    always_comb begin
        pred_taken  = btb_taken;
        pred_target = btb_taken ? btb_target : (pc + FOUR);
    end

    // Resolve the EX instruction against the prediction it carried.
    always_comb begin
        ex_taken_act = op_taken(ex_npc_op, ex_taken);
        actual_next  = ex_taken_act ? ex_target : (ex_pc + FOUR);
        mispredict   = ex_valid && (actual_next != ex_pred_target);
        flush        = mispredict;
        // Training waits out a stall so the EX instruction is seen exactly once.
        btb_wr_en    = ex_valid && !stall;
    end

    // Next-PC priority: redirect beats stall beats the prediction.
    always_comb begin
        pc_d = pred_target;
        if (mispredict) begin
            pc_d = actual_next;
        end else if (stall) begin
            pc_d = pc;
        end
    end

    // Architectural fetch-PC register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

    // Saturating mispredict counter for performance monitoring.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mispred_cnt <= '0;
        end else if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
            mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expectations queued as stimulus is driven,
// popped and checked when the DUT presents the corresponding output.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [4:0]  ex_npc_op;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic [31:0] mispred_cnt;

    pc_gen #(
        .XLEN        (32),
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall          (stall),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_npc_op      (ex_npc_op),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp;
    int          n_mis;
    logic [31:0] exp_cnt;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_mis++;
            $error("FAIL %s: observed %h, no expectation queued", tag, obs);
        end else begin
            e = sb_q.pop_front();
            assert (e.tag == tag && obs === e.v) else begin
                n_mis++;
                $error("FAIL %s: observed %h expected %h (queued as %s)", tag, obs, e.v, e.tag);
            end
        end
    endtask

    // Expect-and-check in one go, for combinational outputs.
    task automatic now(input string tag, input logic [31:0] exp_v, input logic [31:0] obs);
        push(tag, exp_v);
        chk(tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic [4:0] op, input logic [31:0] epc, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_npc_op      = op;
        ex_pc          = epc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    // Steer fetch to t with a sequential instruction at t-4 that carried a
    // wrong prediction; always costs one mispredict.
    task automatic redirect_to(input logic [31:0] t);
        drive_ex(NPC_PLUS4, t - 32'd4, 1'b0, 32'h0, 1'b1, t + 32'h1000);
        #1;
        now("redir_flush", 32'd1, {31'd0, flush});
        exp_cnt = exp_cnt + 32'd1;
        push("redir_pc", t);
        push("redir_cnt", exp_cnt);
        tick();
        ex_valid = 1'b0;
        chk("redir_pc", pc);
        chk("redir_cnt", mispred_cnt);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        exp_cnt = 32'd0;
        rstn = 1'b0;
        stall = 1'b0;
        ex_valid = 1'b0;
        ex_npc_op = NPC_PLUS4;
        ex_pc = '0;
        ex_taken = 1'b0;
        ex_target = '0;
        ex_pred_taken = 1'b0;
        ex_pred_target = '0;

        // Reset state
        #12;
        now("rst_pc", 32'h0, pc);
        now("rst_cnt", 32'h0, mispred_cnt);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        now("post_rst_pc", 32'h0, pc);
        now("post_rst_ptaken", 32'd0, {31'd0, pred_taken});
        now("post_rst_ptgt", 32'h4, pred_target);
        now("post_rst_flush", 32'd0, {31'd0, flush});
        push("idle3_pc", 32'hC);
        tick(); tick(); tick();
        chk("idle3_pc", pc);

        // Taken branch that misses the BTB
        drive_ex(NPC_BRANCH, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #1;
        now("br_miss_flush", 32'd1, {31'd0, flush});
        exp_cnt = exp_cnt + 32'd1;
        push("br_miss_pc", 32'h40);
        push("br_miss_cnt", exp_cnt);
        tick();
        ex_valid = 1'b0;
        chk("br_miss_pc", pc);
        chk("br_miss_cnt", mispred_cnt);
        now("pc40_ptgt", 32'h44, pred_target);
        redirect_to(32'h10);
        now("refetch_ptaken", 32'd1, {31'd0, pred_taken});
        now("refetch_ptgt", 32'h40, pred_target);

        // Not taken: counter 2 -> 1, mispredicted
        drive_ex(NPC_BRANCH, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
        #1;
        now("nt1_flush", 32'd1, {31'd0, flush});
        exp_cnt = exp_cnt + 32'd1;
        push("nt1_pc", 32'h14);
        tick();
        ex_valid = 1'b0;
        chk("nt1_pc", pc);
        redirect_to(32'h10);
        now("ctr1_ptaken", 32'd0, {31'd0, pred_taken});
        now("ctr1_ptgt", 32'h14, pred_target);

        // Not taken twice more, correctly predicted: 1 -> 0 -> 0
        drive_ex(NPC_BRANCH, 32'h10, 1'b0, 32'h40, 1'b0, 32'h14);
        #1;
        now("nt2_flush", 32'd0, {31'd0, flush});
        push("nt2_pc", 32'h14);
        tick();
        chk("nt2_pc", pc);
        drive_ex(NPC_BRANCH, 32'h10, 1'b0, 32'h40, 1'b0, 32'h14);
        #1;
        now("nt3_flush", 32'd0, {31'd0, flush});
        push("nt3_pc", 32'h18);
        push("nt3_cnt", exp_cnt);
        tick();
        chk("nt3_pc", pc);
        chk("nt3_cnt", mispred_cnt);

        // Taken from the floor: 0 -> 1 still predicts not taken
        drive_ex(NPC_BRANCH, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #1;
        now("t_sat_flush", 32'd1, {31'd0, flush});
        exp_cnt = exp_cnt + 32'd1;
        push("t_sat_pc", 32'h40);
        tick();
        ex_valid = 1'b0;
        chk("t_sat_pc", pc);
        redirect_to(32'h10);
        now("sat0_ptaken", 32'd0, {31'd0, pred_taken});
        // Taken again: 1 -> 2 predicts taken
        drive_ex(NPC_BRANCH, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #1;
        exp_cnt = exp_cnt + 32'd1;
        tick();
        ex_valid = 1'b0;
        redirect_to(32'h10);
        now("ctr2_ptaken", 32'd1, {31'd0, pred_taken});
        now("ctr2_ptgt", 32'h40, pred_target);

        // JALR allocation (ex_taken deliberately low: jumps are always taken)
        drive_ex(NPC_JALR, 32'h20, 1'b0, 32'h100, 1'b0, 32'h24);
        #1;
        now("jalr_flush", 32'd1, {31'd0, flush});
        exp_cnt = exp_cnt + 32'd1;
        push("jalr_pc", 32'h100);
        tick();
        ex_valid = 1'b0;
        chk("jalr_pc", pc);
        redirect_to(32'h20);
        now("jalr_ptaken", 32'd1, {31'd0, pred_taken});
        now("jalr_ptgt", 32'h100, pred_target);
        // Retarget to 0x104; lookup in the same cycle still sees 0x100
        drive_ex(NPC_JALR, 32'h20, 1'b0, 32'h104, 1'b1, 32'h100);
        #1;
        now("same_cyc_ptgt", 32'h100, pred_target);
        now("retgt_flush", 32'd1, {31'd0, flush});
        exp_cnt = exp_cnt + 32'd1;
        push("retgt_pc", 32'h104);
        tick();
        ex_valid = 1'b0;
        chk("retgt_pc", pc);
        redirect_to(32'h20);
        now("retgt_ptgt", 32'h104, pred_target);

        // Stall holds pc for 4 cycles
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push("stall_pc", 32'h20);
            tick();
            chk("stall_pc", pc);
        end
        // Mispredict during stall: pc redirects, BTB untouched
        drive_ex(NPC_BRANCH, 32'h30, 1'b1, 32'h80, 1'b0, 32'h34);
        #1;
        now("stall_mp_flush", 32'd1, {31'd0, flush});
        exp_cnt = exp_cnt + 32'd1;
        push("stall_mp_pc", 32'h80);
        push("stall_mp_cnt", exp_cnt);
        tick();
        ex_valid = 1'b0;
        stall = 1'b0;
        chk("stall_mp_pc", pc);
        chk("stall_mp_cnt", mispred_cnt);
        redirect_to(32'h30);
        now("stall_nobtb_ptaken", 32'd0, {31'd0, pred_taken});
        now("stall_nobtb_ptgt", 32'h34, pred_target);

        // Alias slot: 0x50 shares the index of 0x10 with a different tag
        drive_ex(NPC_JUMP, 32'h50, 1'b0, 32'h200, 1'b0, 32'h54);
        #1;
        exp_cnt = exp_cnt + 32'd1;
        push("jump_pc", 32'h200);
        tick();
        ex_valid = 1'b0;
        chk("jump_pc", pc);
        redirect_to(32'h50);
        now("alias_hit_ptaken", 32'd1, {31'd0, pred_taken});
        now("alias_hit_ptgt", 32'h200, pred_target);
        drive_ex(NPC_PLUS4, 32'h50, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        now("alias_flush", 32'd1, {31'd0, flush});
        exp_cnt = exp_cnt + 32'd1;
        push("alias_pc", 32'h54);
        tick();
        ex_valid = 1'b0;
        chk("alias_pc", pc);
        redirect_to(32'h50);
        now("alias_inval_ptaken", 32'd0, {31'd0, pred_taken});
        now("alias_inval_ptgt", 32'h54, pred_target);

        // Reset mid-operation with an EX update pending
        drive_ex(NPC_BRANCH, 32'h60, 1'b1, 32'h90, 1'b0, 32'h64);
        rstn = 1'b0;
        #1;
        now("midrst_pc", 32'h0, pc);
        now("midrst_cnt", 32'h0, mispred_cnt);
        now("midrst_ptgt", 32'h4, pred_target);
        tick();
        ex_valid = 1'b0;
        rstn = 1'b1;
        #1;
        now("midrst_hold_pc", 32'h0, pc);
        exp_cnt = 32'd0;
        redirect_to(32'h60);
        now("midrst_drop_ptaken", 32'd0, {31'd0, pred_taken});
        redirect_to(32'h20);
        now("midrst_clr_ptaken", 32'd0, {31'd0, pred_taken});
        now("midrst_clr_ptgt", 32'h24, pred_target);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised next-PC generator for the pipelined RV32 core, successor to the combinational next-PC mux. It owns the architectural fetch-PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so IF can fetch speculatively. It resolves the prediction against the EX-stage outcome, redirects on mispredict and raises a one-cycle flush. It sits between the IF stage (fetch address) and the EX stage (branch/jump resolution).

## Interface
- XLEN, 32, PC/target width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX = log2(BTB_ENTRIES).
- clk  in  1  core clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- stall  in  1  hold PC (load-use / structural hazard).
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  BTB predicts the instruction at pc is taken.
- pred_target  out  XLEN  predicted next PC: BTB target if pred_taken, else pc+4.
- ex_valid  in  1  EX holds a valid instruction this cycle.
- ex_npc_op  in  5  NPC op from ctrl_encode_def.v (NPC_PLUS4/BRANCH/JUMP/JALR).
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_taken  in  1  resolved branch outcome; ignored for JUMP/JALR (always taken) and PLUS4 (never taken).
- ex_target  in  XLEN  resolved target (PC+IMM or JALR ALU result).
- ex_pred_taken, ex_pred_target  in  1, XLEN  prediction carried down the pipe with the instruction.
- flush  out  1  mispredict this cycle; kill IF/ID and ID/EX.
- mispred_cnt  out  32  saturating mispredict counter.

## Operation
- actual_next = taken ? ex_target : ex_pc+4, where taken = 1 for JUMP/JALR, ex_taken for BRANCH, 0 for PLUS4 and unknown ops.
- mispredict = ex_valid && (actual_next != ex_pred_target). flush = mispredict (combinational).
- PC next-state priority: mispredict → actual_next; else stall → hold; else → pred_target.
- Lookup: index = pc[2+:IDX], tag = pc[XLEN-1:2+IDX]. Hit = valid && tag match. pred_taken = hit && ctr[1].
- Update applies only when ex_valid and not stalled, using the ex_pc index/tag:
  - BRANCH hit: ctr +1 if taken, −1 if not; saturates at 3 and 0. Target rewritten when taken.
  - BRANCH miss, taken: allocate (valid=1, tag, target, ctr=2). Miss, not taken: no allocation.
  - JUMP/JALR: allocate or overwrite with ctr=3 and target=ex_target.
  - PLUS4 with a hit (alias): invalidate the entry.
- mispred_cnt increments on each mispredict and saturates at 32'hFFFF_FFFF.
- Reset clears all valid bits and counters. pc=RESET_PC, pred_taken=0, pred_target=RESET_PC+4, mispred_cnt=0. flush=0 while ex_valid=0.
- rstn asserted mid-operation clears state immediately; pending EX updates are discarded.

## Timing
- pc, BTB and mispred_cnt update on the rising edge of clk. Lookup is combinational from the registered table.
- Redirect latency is 1 cycle: a mispredict seen in cycle N gives pc=actual_next in N+1.
- Same-cycle update and lookup at the same index: the lookup sees the old contents, and the update is visible from the next cycle.
- A mispredict overrides stall in the same cycle. The BTB is not updated that cycle only if stall=1.

## Structure
- NPC_* op codes stay in ctrl_encode_def.v. Add the counter-state macros there (SNT=0, WNT=1, WT=2, ST=3) plus the ctr reset/alloc values.
- Sub-module pc_gen_btb contains the storage and lookup/update ports: valid/tag/target/ctr arrays, one read port and one write port. pc_gen contains the PC register, the resolve logic and the counter.

## Test plan
- Reset: rstn=0 then released → pc=0, pred_target=4, flush=0. After 3 idle cycles pc=12.
- Taken branch miss: ex_pc=0x10, BRANCH, taken, target 0x40, pred_target 0x14 → flush=1, next pc=0x40, entry ctr=2. Refetch of 0x10 → pred_taken=1, pred_target=0x40.
- Saturation: the 0x10 branch is not taken 3 times → ctr goes 2→1→0→0; pred_taken=0 after the first decrement. mispred_cnt increments only when the outcome differs.
- JALR: ex_pc=0x20, target 0x100 → ctr=3, later hit predicts 0x100. Resolved target 0x104 → flush, target rewritten.
- Stall vs redirect: stall=1 holds pc for 4 cycles. stall=1 together with a mispredict → pc=actual_next and the BTB is unchanged.
- Alias: a PLUS4 instruction at 0x10+4·BTB_ENTRIES with ex_pred_taken=1 → flush, pc=ex_pc+4, entry invalidated.
